// File: rtl/bank_pingpong_scheduler_if.sv
// bank_pingpong_scheduler_if: sequencer and engine handshakes around the bank scheduler
interface bank_pingpong_scheduler_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic [CNT_W-1:0] n_rounds;
   logic             ld_gnt;
   logic [1:0]       ld_buf;
   logic             ld_done;
   logic             cp_gnt;
   logic [1:0]       cp_buf;
   logic             cp_done;
   logic             st_gnt;
   logic [1:0]       st_buf;
   logic             st_done;
   logic             busy;
   logic             job_done;
   logic             err_proto;

   modport master (
      input  start, n_rounds, ld_done, cp_done, st_done,
      output ld_gnt, ld_buf, cp_gnt, cp_buf, st_gnt, st_buf, busy, job_done, err_proto
   );

   modport slave (
      output start, n_rounds, ld_done, cp_done, st_done,
      input  ld_gnt, ld_buf, cp_gnt, cp_buf, st_gnt, st_buf, busy, job_done, err_proto
   );
endinterface

// File: rtl/bank_pingpong_scheduler.sv
// bank_pingpong_scheduler: rotates coefficient banks through load, compute and store engines
module bank_pingpong_scheduler #(
   parameter int NBUF  = 2,
   parameter int CNT_W = 8
) (
   input logic                        clk,
   input logic                        rst_n,
   bank_pingpong_scheduler_if.master  bus
);
   typedef enum logic [2:0] {FREE, LOADING, LOADED, COMPUTING, COMPUTED, STORING} bank_e;
   typedef enum logic {IDLE, RUN} job_e;

   job_e             state_q, state_d;
   bank_e            bank_q [4];
   bank_e            bank_d [4];
   logic [CNT_W-1:0] n_q, n_d, loads_q, loads_d, stored_q, stored_d;
   logic [1:0]       ld_ptr_q, ld_ptr_d, cp_ptr_q, cp_ptr_d, st_ptr_q, st_ptr_d;
   logic [1:0]       ld_buf_q, ld_buf_d, cp_buf_q, cp_buf_d, st_buf_q, st_buf_d;
   logic             ld_fl_q, ld_fl_d, cp_fl_q, cp_fl_d, st_fl_q, st_fl_d;
   logic             ld_gnt_q, ld_gnt_d, cp_gnt_q, cp_gnt_d, st_gnt_q, st_gnt_d;
   logic             job_done_q, job_done_d, err_q, err_d;
   logic             start_acc;

   function automatic logic [1:0] nxt(input logic [1:0] p);
      return (p == 2'(NBUF - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   // Next state: accept start, retire done pulses, then issue grants from registered bank states
   always_comb begin
      state_d    = state_q;
      bank_d     = bank_q;
      n_d        = n_q;
      loads_d    = loads_q;
      stored_d   = stored_q;
      ld_ptr_d   = ld_ptr_q;
      cp_ptr_d   = cp_ptr_q;
      st_ptr_d   = st_ptr_q;
      ld_buf_d   = ld_buf_q;
      cp_buf_d   = cp_buf_q;
      st_buf_d   = st_buf_q;
      ld_fl_d    = ld_fl_q;
      cp_fl_d    = cp_fl_q;
      st_fl_d    = st_fl_q;
      ld_gnt_d   = 1'b0;
      cp_gnt_d   = 1'b0;
      st_gnt_d   = 1'b0;
      job_done_d = 1'b0;
      err_d      = err_q;
      start_acc  = bus.start && (state_q == IDLE);
      if (start_acc) begin
         n_d        = bus.n_rounds;
         loads_d    = '0;
         stored_d   = '0;
         ld_ptr_d   = '0;
         cp_ptr_d   = '0;
         st_ptr_d   = '0;
         err_d      = 1'b0;
         state_d    = (bus.n_rounds == '0) ? IDLE : RUN;
         job_done_d = (bus.n_rounds == '0);
      end
      if (bus.ld_done) begin
         if (ld_fl_q) begin
            bank_d[ld_buf_q] = LOADED;
            ld_ptr_d         = nxt(ld_ptr_q);
            ld_fl_d          = 1'b0;
         end else err_d = 1'b1;
      end
      if (bus.cp_done) begin
         if (cp_fl_q) begin
            bank_d[cp_buf_q] = COMPUTED;
            cp_ptr_d         = nxt(cp_ptr_q);
            cp_fl_d          = 1'b0;
         end else err_d = 1'b1;
      end
      if (bus.st_done) begin
         if (st_fl_q) begin
            bank_d[st_buf_q] = FREE;
            st_ptr_d         = nxt(st_ptr_q);
            st_fl_d          = 1'b0;
            stored_d         = stored_q + CNT_W'(1);
         end else err_d = 1'b1;
      end
      if (state_q == RUN && loads_q < n_q && bank_q[ld_ptr_q] == FREE && !ld_fl_q) begin
         ld_gnt_d         = 1'b1;
         ld_buf_d         = ld_ptr_q;
         bank_d[ld_ptr_q] = LOADING;
         loads_d          = loads_q + CNT_W'(1);
         ld_fl_d          = 1'b1;
      end
      if (state_q == RUN && bank_q[cp_ptr_q] == LOADED && !cp_fl_q) begin
         cp_gnt_d         = 1'b1;
         cp_buf_d         = cp_ptr_q;
         bank_d[cp_ptr_q] = COMPUTING;
         cp_fl_d          = 1'b1;
      end
      if (state_q == RUN && bank_q[st_ptr_q] == COMPUTED && !st_fl_q) begin
         st_gnt_d         = 1'b1;
         st_buf_d         = st_ptr_q;
         bank_d[st_ptr_q] = STORING;
         st_fl_d          = 1'b1;
      end
      if (state_q == RUN && stored_d == n_q) begin
         state_d    = IDLE;
         job_done_d = 1'b1;
      end
   end

   // State registers with asynchronous clear of every bank, pointer, counter and output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bank_q     <= '{default: FREE};
         n_q        <= '0;
         loads_q    <= '0;
         stored_q   <= '0;
         ld_ptr_q   <= '0;
         cp_ptr_q   <= '0;
         st_ptr_q   <= '0;
         ld_buf_q   <= '0;
         cp_buf_q   <= '0;
         st_buf_q   <= '0;
         ld_fl_q    <= 1'b0;
         cp_fl_q    <= 1'b0;
         st_fl_q    <= 1'b0;
         ld_gnt_q   <= 1'b0;
         cp_gnt_q   <= 1'b0;
         st_gnt_q   <= 1'b0;
         job_done_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bank_q     <= bank_d;
         n_q        <= n_d;
         loads_q    <= loads_d;
         stored_q   <= stored_d;
         ld_ptr_q   <= ld_ptr_d;
         cp_ptr_q   <= cp_ptr_d;
         st_ptr_q   <= st_ptr_d;
         ld_buf_q   <= ld_buf_d;
         cp_buf_q   <= cp_buf_d;
         st_buf_q   <= st_buf_d;
         ld_fl_q    <= ld_fl_d;
         cp_fl_q    <= cp_fl_d;
         st_fl_q    <= st_fl_d;
         ld_gnt_q   <= ld_gnt_d;
         cp_gnt_q   <= cp_gnt_d;
         st_gnt_q   <= st_gnt_d;
         job_done_q <= job_done_d;
         err_q      <= err_d;
      end
   end

   assign bus.ld_gnt    = ld_gnt_q;
   assign bus.ld_buf    = ld_buf_q;
   assign bus.cp_gnt    = cp_gnt_q;
   assign bus.cp_buf    = cp_buf_q;
   assign bus.st_gnt    = st_gnt_q;
   assign bus.st_buf    = st_buf_q;
   assign bus.busy      = (state_q == RUN);
   assign bus.job_done  = job_done_q;
   assign bus.err_proto = err_q;
endmodule

// File: tb/tb_bank_pingpong_scheduler.sv
// tb_bank_pingpong_scheduler: directed jobs with latency-modelled engines and a grant scoreboard
module tb_bank_pingpong_scheduler;
   localparam int NBUF = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bank_pingpong_scheduler_if #(.CNT_W(8)) bus ();
   bank_pingpong_scheduler #(.NBUF(NBUF), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_pass = 0;
   int n_total = 0;
   int ld_lat = 3, cp_lat = 3, st_lat = 3;
   int ld_t, cp_t, st_t;
   int n_ld, n_cp, n_st, ld_app, cp_app, st_app, jd_seen, cur_n;
   bit ld_fl, cp_fl, st_fl;
   logic [1:0] exp_ld[$];
   logic [1:0] exp_cp[$];
   logic [1:0] exp_st[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic new_job(input int n);
      exp_ld.delete();
      exp_cp.delete();
      exp_st.delete();
      for (int i = 0; i < n; i++) begin
         exp_ld.push_back(2'(i % NBUF));
         exp_cp.push_back(2'(i % NBUF));
         exp_st.push_back(2'(i % NBUF));
      end
      n_ld = 0; n_cp = 0; n_st = 0;
      ld_app = 0; cp_app = 0; st_app = 0;
      jd_seen = 0; cur_n = n;
      ld_fl = 0; cp_fl = 0; st_fl = 0;
      ld_t = 0; cp_t = 0; st_t = 0;
   endtask

   // One clock: check grants against the model, retire sampled dones, then drive engine responses
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.ld_gnt) begin
         n_ld++;
         chk("ld_idle", 32'(ld_fl), 0);
         chk("ld_occ", 32'((n_ld - st_app) <= NBUF), 1);
         if (exp_ld.size() > 0) chk("ld_buf", 32'(bus.ld_buf), 32'(exp_ld.pop_front()));
         else chk("ld_extra", 1, 0);
      end
      if (bus.cp_gnt) begin
         n_cp++;
         chk("cp_idle", 32'(cp_fl), 0);
         chk("cp_after_ld", 32'(n_cp <= ld_app), 1);
         if (exp_cp.size() > 0) chk("cp_buf", 32'(bus.cp_buf), 32'(exp_cp.pop_front()));
         else chk("cp_extra", 1, 0);
      end
      if (bus.st_gnt) begin
         n_st++;
         chk("st_idle", 32'(st_fl), 0);
         chk("st_after_cp", 32'(n_st <= cp_app), 1);
         if (exp_st.size() > 0) chk("st_buf", 32'(bus.st_buf), 32'(exp_st.pop_front()));
         else chk("st_extra", 1, 0);
      end
      if (bus.ld_done && ld_fl) begin ld_app++; ld_fl = 0; end
      if (bus.cp_done && cp_fl) begin cp_app++; cp_fl = 0; end
      if (bus.st_done && st_fl) begin st_app++; st_fl = 0; end
      if (bus.job_done) begin
         jd_seen++;
         chk("busy_at_jd", 32'(bus.busy), 0);
         chk("jd_stored", st_app, cur_n);
      end
      bus.ld_done = 1'b0;
      bus.cp_done = 1'b0;
      bus.st_done = 1'b0;
      if (ld_t > 0) begin ld_t--; if (ld_t == 0) bus.ld_done = 1'b1; end
      if (cp_t > 0) begin cp_t--; if (cp_t == 0) bus.cp_done = 1'b1; end
      if (st_t > 0) begin st_t--; if (st_t == 0) bus.st_done = 1'b1; end
      if (bus.ld_gnt) begin ld_fl = 1; ld_t = ld_lat; end
      if (bus.cp_gnt) begin cp_fl = 1; cp_t = cp_lat; end
      if (bus.st_gnt) begin st_fl = 1; st_t = st_lat; end
   endtask

   task automatic start_job(input int n);
      new_job(n);
      bus.n_rounds = 8'(n);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      int k = 0;
      while (jd_seen == 0 && k < 3000) begin
         tick();
         k++;
      end
      chk("jd_timeout", 32'(jd_seen != 0), 1);
      repeat (6) tick();
   endtask

   task automatic end_checks(input string tag);
      chk({tag, "_n_ld"}, n_ld, cur_n);
      chk({tag, "_n_cp"}, n_cp, cur_n);
      chk({tag, "_n_st"}, n_st, cur_n);
      chk({tag, "_jd_once"}, jd_seen, 1);
      chk({tag, "_busy_end"}, 32'(bus.busy), 0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.n_rounds = '0;
      bus.ld_done = 1'b0;
      bus.cp_done = 1'b0;
      bus.st_done = 1'b0;
      new_job(0);
      repeat (2) @(posedge clk);
      chk("rst_outs", 32'({bus.busy, bus.ld_gnt, bus.cp_gnt, bus.st_gnt, bus.ld_buf, bus.cp_buf,
                           bus.st_buf, bus.job_done, bus.err_proto}), 0);
      #1 rst_n = 1'b1;
      tick();

      start_job(2);
      chk("t1_busy", 32'(bus.busy), 1);
      wait_done();
      end_checks("t1");
      chk("t1_err", 32'(bus.err_proto), 0);

      st_lat = 20;
      start_job(5);
      wait_done();
      end_checks("t2");
      st_lat = 3;

      start_job(0);
      chk("t3_jd", 32'(bus.job_done), 1);
      chk("t3_busy", 32'(bus.busy), 0);
      repeat (8) begin
         tick();
         chk("t3_busy_low", 32'(bus.busy), 0);
      end
      chk("t3_no_gnt", n_ld + n_cp + n_st, 0);
      chk("t3_jd_once", jd_seen, 1);

      start_job(2);
      bus.cp_done = 1'b1;
      tick();
      chk("t4_err", 32'(bus.err_proto), 1);
      wait_done();
      end_checks("t4");
      chk("t4_err_hold", 32'(bus.err_proto), 1);

      start_job(3);
      chk("t5_err_clr", 32'(bus.err_proto), 0);
      repeat (10) tick();
      chk("t5_busy_mid", 32'(bus.busy), 1);
      bus.n_rounds = 8'd7;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done();
      end_checks("t5");

      start_job(3);
      for (int k = 0; k < 500 && n_cp < 2; k++) tick();
      chk("t6_cp2", n_cp, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_outs", 32'({bus.busy, bus.ld_gnt, bus.cp_gnt, bus.st_gnt, bus.ld_buf, bus.cp_buf,
                              bus.st_buf, bus.job_done, bus.err_proto}), 0);
      bus.ld_done = 1'b0;
      bus.cp_done = 1'b0;
      bus.st_done = 1'b0;
      new_job(0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      start_job(2);
      chk("t6_busy", 32'(bus.busy), 1);
      wait_done();
      end_checks("t6");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/bank_pingpong_scheduler.md
Name: bank_pingpong_scheduler

Overview:
- Schedules ownership of NBUF coefficient buffer banks shared by three engines: DRAM loader, NTT/INTT/PWM compute array, DRAM storer.
- Each bank cycles FREE -> LOADING -> LOADED -> COMPUTING -> COMPUTED -> STORING -> FREE.
- Issues one-cycle grant pulses with a bank index to each engine so load, compute and store of different rounds overlap.
- Sits between the top-level sequencer (start/round count) and the engine start/done handshakes.

Parameters:
- NBUF, 2, number of banks (2..4); bank index width BW = 2.
- CNT_W, 8, width of round counters and n_rounds.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin a job of n_rounds rounds
- n_rounds  in  CNT_W  rounds in job; sampled on accepted start
- ld_gnt  out  1  pulse; loader may fill bank ld_buf
- ld_buf  out  2  bank index for loader; held until next ld_gnt
- ld_done  in  1  pulse; loader finished current bank
- cp_gnt  out  1  pulse; compute array may process bank cp_buf
- cp_buf  out  2  bank index for compute
- cp_done  in  1  pulse; compute finished current bank
- st_gnt  out  1  pulse; storer may drain bank st_buf
- st_buf  out  2  bank index for storer
- st_done  in  1  pulse; storer finished current bank
- busy  out  1  job active
- job_done  out  1  pulse; all n_rounds stored
- err_proto  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, any time including mid-job): all banks FREE; pointers, counters and in-flight flags 0; all outputs 0. Synchronous operation resumes on the first clk edge after rst_n rises.
- Accepted start: start=1 while busy=0. It latches n_rounds, zeroes the ld/cp/st pointers and the issued/stored counters, clears err_proto, and sets busy next cycle.
- start while busy=1: ignored, no state change.
- Per-engine in-flight flag: set on that engine's grant, cleared on its done.
- Loader grant condition (all true): busy, loads_issued < n_rounds, bank[ld_ptr]==FREE, loader not in flight.
- When the loader condition holds, the next edge does:
  - ld_gnt=1 for exactly one cycle;
  - ld_buf<=ld_ptr;
  - bank -> LOADING;
  - loads_issued+1.
- ld_done with loader in flight: bank[ld_buf] -> LOADED; ld_ptr <= (ld_ptr+1) mod NBUF.
- Compute: same structure with cp_ptr. Grants when bank[cp_ptr]==LOADED and compute is idle (-> COMPUTING). cp_done -> COMPUTED, cp_ptr advances.
- Store: same structure with st_ptr. Grants when bank[st_ptr]==COMPUTED and storer is idle (-> STORING). st_done -> FREE, st_ptr advances, stored+1.
- Grant latency:
  - A grant is registered; it appears one cycle after the enabling state is registered.
  - Minimum: done at edge t gives the next grant for the same engine at edge t+1.
  - A bank freed by st_done at edge t can be granted to the loader at edge t+1.
- Simultaneous done pulses on different engines in one cycle are all applied in that cycle. Order of grants among engines is independent.
- Job completion: when stored reaches n_rounds, job_done=1 for one cycle and busy=0 in the same cycle; no further grants.
- n_rounds=0: job_done pulses on the edge after the accepted start; busy never rises; no grants.
- Protocol errors: a done pulse with its engine not in flight is ignored for state and sets err_proto=1. err_proto holds until reset or the next accepted start.
- Pointers wrap modulo NBUF. Counters never exceed n_rounds (loads stop issuing at n_rounds).

Test Plan:
- NBUF=2, n_rounds=2, each engine answers done 3 cycles after its grant -> grants in order: ld0, ld1 (granted after ld_done of bank 0), cp0, cp1, st0, st1; banks alternate 0,1; job_done once after the second st_done; busy low in the same cycle.
- NBUF=2, n_rounds=5, slow storer (done 20 cycles after grant) -> loader stalls with both banks occupied; no ld_gnt until st_done; exactly 5 of each grant; ld_buf sequence 0,1,0,1,0.
- start with n_rounds=0 -> job_done one cycle later; ld_gnt/cp_gnt/st_gnt never asserted; busy stays 0.
- Spurious cp_done while compute idle -> err_proto=1, bank states unchanged, job still completes; next accepted start clears err_proto.
- start pulsed mid-job (n_rounds=3 job, second start with n_rounds=7) -> ignored; job_done after 3 stores.
- rst_n asserted during COMPUTING of round 2 -> all outputs 0 immediately; a new start then runs n_rounds=2 from bank 0 correctly.
